// File: rtl/param_learning_neuron.sv
// Single neuron with a serial multiply-accumulate forward pass and an
// in-place gradient-descent update of its weights and bias.
module param_learning_neuron #(
    parameter int N_IN     = 8,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int LR_SHIFT = 4,
    parameter int ACT_MODE = 1
) (
    input  logic                      ln_clock,
    input  logic                      ln_reset_n,
    input  logic                      ln_in_valid,
    output logic                      ln_in_ready,
    input  logic [N_IN*DATA_W-1:0]    ln_dendrites,
    input  logic [N_IN-1:0]           ln_enabled,
    input  logic                      ln_train,
    output logic                      ln_out_valid,
    input  logic                      ln_out_ready,
    output logic [DATA_W-1:0]         ln_axon,
    input  logic                      ln_bp_valid,
    output logic                      ln_bp_ready,
    input  logic [DATA_W-1:0]         ln_backprop,
    output logic [N_IN*DATA_W-1:0]    ln_bp_change,
    output logic                      ln_bp_change_valid,
    input  logic                      ln_w_load,
    input  logic [$clog2(N_IN+1)-1:0] ln_w_idx,
    input  logic [DATA_W-1:0]         ln_w_data
);

    localparam int IW = $clog2(N_IN + 1);
    localparam int PW = 2 * DATA_W;
    localparam int AW = PW + IW;
    localparam bit RELU = (ACT_MODE == 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
    localparam logic signed [DATA_W-1:0] ONE_Q = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

    typedef enum logic [2:0] {IDLE, FWD, ACT, OUT, WAIT_BP, UPD} state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = v[DATA_W-1:0];
        end
    endfunction

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    // Slot N_IN holds a constant 1.0 with its mask bit forced on, so the
    // bias is processed by the same datapath as the dendrite weights.
    logic signed [DATA_W-1:0]  x_q [0:N_IN];
    logic signed [DATA_W-1:0]  x_d [0:N_IN];
    logic signed [DATA_W-1:0]  w_q [0:N_IN];
    logic signed [DATA_W-1:0]  w_d [0:N_IN];
    logic [N_IN:0]             mask_q, mask_d;
    logic                      train_q, train_d;
    logic signed [DATA_W-1:0]  pre_q, pre_d;
    logic signed [DATA_W-1:0]  axon_q, axon_d;
    logic signed [DATA_W-1:0]  e_q, e_d;
    logic [N_IN*DATA_W-1:0]    bp_change_q, bp_change_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      bp_ready_q, bp_ready_d;
    logic                      bp_change_valid_q, bp_change_valid_d;

    logic signed [DATA_W-1:0]  x_sel_s, w_sel_s;
    logic                      m_sel_s;
    logic signed [PW-1:0]      fwd_prod_s, err_w_prod_s, err_x_prod_s;
    logic signed [DATA_W-1:0]  pre_s, w_upd_s, bp_j_s;

    // Datapath terms for the slot selected by idx_q.
    always_comb begin
        x_sel_s      = x_q[idx_q];
        w_sel_s      = w_q[idx_q];
        m_sel_s      = mask_q[idx_q];
        fwd_prod_s   = PW'(x_sel_s) * PW'(w_sel_s);
        err_w_prod_s = PW'(e_q) * PW'(w_sel_s);
        err_x_prod_s = PW'(e_q) * PW'(x_sel_s);
        pre_s        = sat(acc_q >>> FRAC_W);
        w_upd_s      = sat(AW'(w_sel_s) - AW'(err_x_prod_s >>> (FRAC_W + LR_SHIFT)));
        bp_j_s       = sat(AW'(err_w_prod_s >>> FRAC_W));
    end

    // Next-state and next-output logic of the neuron FSM.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        acc_d             = acc_q;
        x_d               = x_q;
        w_d               = w_q;
        mask_d            = mask_q;
        train_d           = train_q;
        pre_d             = pre_q;
        axon_d            = axon_q;
        e_d               = e_q;
        bp_change_d       = bp_change_q;
        in_ready_d        = in_ready_q;
        out_valid_d       = out_valid_q;
        bp_ready_d        = bp_ready_q;
        bp_change_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ln_w_load && (ln_w_idx <= LAST_IDX)) begin
                    w_d[ln_w_idx] = ln_w_data;
                end else begin
                    w_d = w_q;
                end
                if (ln_in_valid && in_ready_q) begin
                    for (int i = 0; i < N_IN; i++) begin
                        x_d[i] = ln_dendrites[i*DATA_W +: DATA_W];
                    end
                    x_d[N_IN]          = ONE_Q;
                    mask_d[N_IN-1:0]   = ln_enabled;
                    mask_d[N_IN]       = 1'b1;
                    train_d            = ln_train;
                    acc_d              = {AW{1'b0}};
                    idx_d              = {IW{1'b0}};
                    in_ready_d         = 1'b0;
                    state_d            = FWD;
                end else begin
                    state_d = IDLE;
                end
            end
            FWD: begin
                if (m_sel_s) begin
                    acc_d = acc_q + AW'(fwd_prod_s);
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = {IW{1'b0}};
                    state_d = ACT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ACT: begin
                pre_d       = pre_s;
                axon_d      = (RELU && pre_s[DATA_W-1]) ? ZERO_W : pre_s;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (ln_out_ready) begin
                    out_valid_d = 1'b0;
                    if (train_q) begin
                        bp_ready_d = 1'b1;
                        state_d    = WAIT_BP;
                    end else begin
                        in_ready_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            WAIT_BP: begin
                if (ln_bp_valid) begin
                    // A clipped ReLU has zero gradient, so the error is dropped.
                    if (RELU && (pre_q[DATA_W-1] || (pre_q == ZERO_W))) begin
                        e_d = ZERO_W;
                    end else begin
                        e_d = ln_backprop;
                    end
                    bp_ready_d = 1'b0;
                    idx_d      = {IW{1'b0}};
                    state_d    = UPD;
                end else begin
                    state_d = WAIT_BP;
                end
            end
            UPD: begin
                w_d[idx_q] = m_sel_s ? w_upd_s : ZERO_W;
                for (int j = 0; j < N_IN; j++) begin
                    bp_change_d[j*DATA_W +: DATA_W] = (idx_q == IW'(j)) ?
                        (m_sel_s ? bp_j_s : ZERO_W) : bp_change_q[j*DATA_W +: DATA_W];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d             = {IW{1'b0}};
                    bp_change_valid_d = 1'b1;
                    in_ready_d        = 1'b1;
                    state_d           = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                out_valid_d = 1'b0;
                bp_ready_d  = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge ln_clock) begin
        if (!ln_reset_n) begin
            state_q           <= IDLE;
            idx_q             <= {IW{1'b0}};
            acc_q             <= {AW{1'b0}};
            x_q               <= '{default: {DATA_W{1'b0}}};
            w_q               <= '{default: {DATA_W{1'b0}}};
            mask_q            <= {(N_IN+1){1'b0}};
            train_q           <= 1'b0;
            pre_q             <= {DATA_W{1'b0}};
            axon_q            <= {DATA_W{1'b0}};
            e_q               <= {DATA_W{1'b0}};
            bp_change_q       <= {(N_IN*DATA_W){1'b0}};
            in_ready_q        <= 1'b1;
            out_valid_q       <= 1'b0;
            bp_ready_q        <= 1'b0;
            bp_change_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            acc_q             <= acc_d;
            x_q               <= x_d;
            w_q               <= w_d;
            mask_q            <= mask_d;
            train_q           <= train_d;
            pre_q             <= pre_d;
            axon_q            <= axon_d;
            e_q               <= e_d;
            bp_change_q       <= bp_change_d;
            in_ready_q        <= in_ready_d;
            out_valid_q       <= out_valid_d;
            bp_ready_q        <= bp_ready_d;
            bp_change_valid_q <= bp_change_valid_d;
        end
    end

    assign ln_in_ready        = in_ready_q;
    assign ln_out_valid       = out_valid_q;
    assign ln_axon            = axon_q;
    assign ln_bp_ready        = bp_ready_q;
    assign ln_bp_change       = bp_change_q;
    assign ln_bp_change_valid = bp_change_valid_q;

endmodule

// File: tb/tb_param_learning_neuron.sv
// Drives a ReLU and a linear neuron with shared stimulus and checks both
// against an arithmetic reference model of forward pass and weight update.
module tb_param_learning_neuron;

    localparam int N_IN = 4;
    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int LR   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, in_valid, train, out_ready, bp_valid, w_load;
    logic [N_IN*DW-1:0] dendrites;
    logic [N_IN-1:0]   enabled;
    logic [DW-1:0]     backprop, w_data;
    logic [2:0]        w_idx;

    logic              ra_in_ready, ra_out_valid, ra_bp_ready, ra_bpc_valid;
    logic [DW-1:0]     ra_axon;
    logic [N_IN*DW-1:0] ra_bpc;
    logic              rb_in_ready, rb_out_valid, rb_bp_ready, rb_bpc_valid;
    logic [DW-1:0]     rb_axon;
    logic [N_IN*DW-1:0] rb_bpc;

    param_learning_neuron #(.N_IN(N_IN), .DATA_W(DW), .FRAC_W(FW), .LR_SHIFT(LR), .ACT_MODE(1)) u_relu (
        .ln_clock(clk), .ln_reset_n(rst_n),
        .ln_in_valid(in_valid), .ln_in_ready(ra_in_ready),
        .ln_dendrites(dendrites), .ln_enabled(enabled), .ln_train(train),
        .ln_out_valid(ra_out_valid), .ln_out_ready(out_ready), .ln_axon(ra_axon),
        .ln_bp_valid(bp_valid), .ln_bp_ready(ra_bp_ready), .ln_backprop(backprop),
        .ln_bp_change(ra_bpc), .ln_bp_change_valid(ra_bpc_valid),
        .ln_w_load(w_load), .ln_w_idx(w_idx), .ln_w_data(w_data)
    );

    param_learning_neuron #(.N_IN(N_IN), .DATA_W(DW), .FRAC_W(FW), .LR_SHIFT(LR), .ACT_MODE(0)) u_lin (
        .ln_clock(clk), .ln_reset_n(rst_n),
        .ln_in_valid(in_valid), .ln_in_ready(rb_in_ready),
        .ln_dendrites(dendrites), .ln_enabled(enabled), .ln_train(train),
        .ln_out_valid(rb_out_valid), .ln_out_ready(out_ready), .ln_axon(rb_axon),
        .ln_bp_valid(bp_valid), .ln_bp_ready(rb_bp_ready), .ln_backprop(backprop),
        .ln_bp_change(rb_bpc), .ln_bp_change_valid(rb_bpc_valid),
        .ln_w_load(w_load), .ln_w_idx(w_idx), .ln_w_data(w_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: index 0 = ReLU neuron, index 1 = linear neuron.
    longint wm [2][5];
    longint pre_m [2];
    longint bpc_m [2][4];
    longint xs [4];
    logic [3:0] mk;
    longint last_axon_a, last_axon_b, last_bpc0_a;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return v;
    endfunction

    function automatic longint rnd(input longint lo, input longint hi);
        return lo + longint'($urandom_range(0, int'(hi - lo)));
    endfunction

    function automatic longint axon_exp(input int m);
        if (m == 0 && pre_m[0] < 0) return 0;
        else return pre_m[m];
    endfunction

    task automatic model_forward();
        for (int m = 0; m < 2; m++) begin
            longint sum = wm[m][4] * 256;
            for (int i = 0; i < N_IN; i++)
                if (mk[i]) sum += xs[i] * wm[m][i];
            pre_m[m] = sat16(sum >>> FW);
        end
    endtask

    task automatic model_train(input longint e);
        for (int m = 0; m < 2; m++) begin
            longint ee = (m == 0 && pre_m[0] <= 0) ? 0 : e;
            for (int j = 0; j < N_IN; j++) begin
                bpc_m[m][j] = mk[j] ? sat16((ee * wm[m][j]) >>> FW) : 0;
                wm[m][j]    = mk[j] ? sat16(wm[m][j] - ((ee * xs[j]) >>> (FW + LR))) : 0;
            end
            wm[m][4] = sat16(wm[m][4] - (ee >>> LR));
        end
    endtask

    task automatic load_w(input int idx, input longint v);
        w_load = 1'b1;
        w_idx  = 3'(idx);
        w_data = v[15:0];
        @(negedge clk);
        w_load = 1'b0;
        if (idx <= N_IN) begin
            wm[0][idx] = v;
            wm[1][idx] = v;
        end
    endtask

    task automatic load_all(input longint a, input longint b, input longint c, input longint d, input longint bias);
        load_w(0, a); load_w(1, b); load_w(2, c); load_w(3, d); load_w(4, bias);
    endtask

    task automatic run_sample(input bit tr, input longint e, input bit ld, input int lidx,
                              input longint ldat, input bit rst_mid);
        int lat;
        int pulses;
        in_valid = 1'b1;
        for (int i = 0; i < N_IN; i++) dendrites[i*DW +: DW] = xs[i][15:0];
        enabled = mk;
        train   = tr;
        if (ld) begin
            w_load = 1'b1; w_idx = 3'(lidx); w_data = ldat[15:0];
            if (lidx <= N_IN) begin wm[0][lidx] = ldat; wm[1][lidx] = ldat; end
        end
        @(negedge clk);
        in_valid = 1'b0;
        model_forward();
        check("in_ready_drop", {30'd0, ra_in_ready, rb_in_ready}, 0);
        // A weight write outside IDLE must be ignored.
        w_load = 1'b1; w_idx = 3'($urandom_range(0, 7)); w_data = 16'($urandom);
        lat = 0;
        while (!ra_out_valid && lat < 40) begin
            @(negedge clk);
            w_load = 1'b0;
            lat++;
        end
        w_load = 1'b0;
        check("out_latency", lat, 6);
        check("out_valid_lin", rb_out_valid, 1);
        check("axon_relu", longint'($signed(ra_axon)), axon_exp(0));
        check("axon_lin", longint'($signed(rb_axon)), axon_exp(1));
        last_axon_a = longint'($signed(ra_axon));
        last_axon_b = longint'($signed(rb_axon));
        repeat ($urandom_range(1, 2)) @(negedge clk);
        check("out_hold", {31'd0, ra_out_valid & rb_out_valid}, 1);
        check("axon_stable", longint'($signed(ra_axon)), axon_exp(0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (!tr) begin
            check("idle_after_out", {30'd0, ra_in_ready, rb_in_ready}, 3);
        end else begin
            check("bp_ready_up", {30'd0, ra_bp_ready, rb_bp_ready}, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            backprop = e[15:0];
            bp_valid = 1'b1;
            @(negedge clk);
            bp_valid = 1'b0;
            check("bp_ready_drop", {30'd0, ra_bp_ready, rb_bp_ready}, 0);
            if (rst_mid) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("rst_in_ready", {30'd0, ra_in_ready, rb_in_ready}, 3);
                check("rst_bpc", longint'(ra_bpc | rb_bpc), 0);
                check("rst_axon", longint'(ra_axon | rb_axon), 0);
                pulses = 0;
                for (int k = 0; k < 8; k++) begin
                    if (ra_bpc_valid || rb_bpc_valid) pulses++;
                    @(negedge clk);
                end
                check("rst_no_pulse", pulses, 0);
                for (int m = 0; m < 2; m++)
                    for (int i = 0; i < 5; i++) wm[m][i] = 0;
            end else begin
                model_train(e);
                lat = 0;
                while (!ra_bpc_valid && lat < 40) begin
                    @(negedge clk);
                    lat++;
                end
                check("bpc_latency", lat, 5);
                check("bpc_valid_lin", rb_bpc_valid, 1);
                for (int j = 0; j < N_IN; j++) begin
                    check("bpc_relu", longint'($signed(ra_bpc[j*DW +: DW])), bpc_m[0][j]);
                    check("bpc_lin", longint'($signed(rb_bpc[j*DW +: DW])), bpc_m[1][j]);
                end
                last_bpc0_a = longint'($signed(ra_bpc[DW-1:0]));
                check("idle_after_upd", {30'd0, ra_in_ready, rb_in_ready}, 3);
                @(negedge clk);
                check("bpc_pulse_end", {30'd0, ra_bpc_valid, rb_bpc_valid}, 0);
                check("bpc_hold", longint'($signed(ra_bpc[DW-1:0])), bpc_m[0][0]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; train = 1'b0; out_ready = 1'b0; bp_valid = 1'b0;
        w_load = 1'b0; dendrites = '0; enabled = '0; backprop = '0; w_data = '0; w_idx = '0;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++) wm[m][i] = 0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {30'd0, ra_out_valid, rb_out_valid}, 0);
        check("rst_bp_ready", {30'd0, ra_bp_ready, rb_bp_ready}, 0);
        check("rst_bpc_valid", {30'd0, ra_bpc_valid, rb_bpc_valid}, 0);
        check("rst_axon0", longint'(ra_axon | rb_axon), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready1", {30'd0, ra_in_ready, rb_in_ready}, 3);

        // Stray output/backprop handshakes in IDLE are ignored.
        out_ready = 1'b1; bp_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; bp_valid = 1'b0;
        check("stray_hs", {28'd0, ra_in_ready, ra_out_valid, ra_bp_ready, ra_bpc_valid}, 8);

        // Basic forward pass: 1*1 + 2*0.5 + 1*(-1) + 3*0 + 0.25 = 1.25.
        load_all(256, 128, -256, 0, 64);
        xs = '{256, 512, 256, 768}; mk = 4'b1111;
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("fwd_320_relu", last_axon_a, 320);
        check("fwd_320_lin", last_axon_b, 320);

        // Only input 1 enabled; training zeroes the masked weights.
        mk = 4'b0010;
        run_sample(1'b1, 256, 1'b0, 0, 0, 1'b0);
        check("mask_axon", last_axon_a, 320);
        xs = '{256, 0, 256, 256}; mk = 4'b1111;
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("masked_w_zero", last_axon_a, 48);

        // Single-weight update: w0 1.0 -> 240, bias -16.
        load_all(256, 0, 0, 0, 0);
        xs = '{256, 0, 0, 0}; mk = 4'b0001;
        run_sample(1'b1, 256, 1'b0, 0, 0, 1'b0);
        check("bpc0_256", last_bpc0_a, 256);
        run_sample(1'b1, 256, 1'b0, 0, 0, 1'b0);
        check("w0_240_axon", last_axon_a, 224);
        check("w0_240_bpc", last_bpc0_a, 240);

        // Negative pre-activation blocks the ReLU gradient.
        load_all(-128, 0, 0, 0, 0);
        xs = '{256, 0, 0, 0}; mk = 4'b1111;
        run_sample(1'b1, 256, 1'b0, 0, 0, 1'b0);
        check("relu_clip", last_axon_a, 0);
        check("lin_neg", last_axon_b, -128);
        check("relu_no_bpc", last_bpc0_a, 0);
        xs = '{-256, 0, 0, 0};
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("relu_w_kept", last_axon_a, 128);

        // Saturation of the activated output.
        load_all(32767, 32767, 32767, 32767, 32767);
        xs = '{32767, 32767, 32767, 32767};
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("sat_pos", last_axon_b, 32767);
        xs = '{-32768, -32768, -32768, -32768};
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("sat_neg_lin", last_axon_b, -32768);
        check("sat_neg_relu", last_axon_a, 0);

        // Weight write in the accept cycle is used by that pass.
        load_all(0, 0, 0, 0, 0);
        xs = '{256, 256, 256, 256}; mk = 4'b1111;
        run_sample(1'b0, 0, 1'b1, 4, 512, 1'b0);
        check("load_at_accept", last_axon_b, 512);

        // Randomized samples.
        for (int it = 0; it < 24; it++) begin
            bit big;
            big = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < 5; i++)
                load_w(i, big ? rnd(-32768, 32767) : rnd(-512, 512));
            if ($urandom_range(0, 3) == 0) load_w($urandom_range(5, 7), rnd(-32768, 32767));
            for (int i = 0; i < N_IN; i++) xs[i] = big ? rnd(-32768, 32767) : rnd(-1024, 1024);
            mk = 4'($urandom);
            run_sample(1'($urandom), big ? rnd(-32768, 32767) : rnd(-1024, 1024),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, 7), rnd(-512, 512), 1'b0);
        end

        // Reset during the third update cycle.
        load_all(300, -200, 100, 50, 25);
        xs = '{256, 256, 256, 256}; mk = 4'b1111;
        run_sample(1'b1, 256, 1'b0, 0, 0, 1'b1);
        run_sample(1'b0, 0, 1'b0, 0, 0, 1'b0);
        check("weights_cleared", last_axon_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
